// File: rtl/obj_bg_palette_mixer.sv
// rtl/obj_bg_palette_mixer.sv - layer priority mux, palette RAM lookup and blanking for final pixel output
module obj_bg_palette_mixer #(
  parameter int PAL_AW    = 9,
  parameter int CLEAR_LEN = 512
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        CE_PIX,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic [19:0] A,
  input  logic [1:0]  BYTE_SEL,
  input  logic        PAL_CS,
  input  logic        MRD,
  input  logic        MWR,
  input  logic        HBLK,
  input  logic        VBLK,
  input  logic [7:0]  spr_pix,
  input  logic [7:0]  bga_pix,
  input  logic        bga_prio,
  input  logic [7:0]  bgb_pix,
  input  logic        bgb_prio,
  input  logic [2:0]  layer_en,
  output logic        busy,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue
);

  localparam int DEPTH = 1 << PAL_AW;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [PAL_AW-1:0]   clear_cnt;
  logic                clear_last;

  logic [4:0] pal_r [0:DEPTH-1];
  logic [4:0] pal_g [0:DEPTH-1];
  logic [4:0] pal_b [0:DEPTH-1];

  logic [1:0]        cpu_comp;
  logic [PAL_AW-1:0] cpu_addr;
  logic              cpu_we;
  logic [PAL_AW-1:0] wr_addr;
  logic [4:0]        wr_data;
  logic              wr_r, wr_g, wr_b;
  logic [4:0]        cpu_rd;

  logic              spr_op, bga_op, bgb_op;
  logic [8:0]        pix_idx;

  logic [PAL_AW-1:0] s1_idx;
  logic              s1_blank;
  logic [4:0]        s2_r, s2_g, s2_b;
  logic              s2_blank;

  logic unused;
  assign unused = ^{A[19:12], A[0], DIN[15:5], BYTE_SEL[1]};

  // Clear sequencer
  assign clear_last = (clear_cnt == PAL_AW'(CLEAR_LEN - 1));
  assign busy       = (state_q == ST_CLEAR);

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clear_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR)
        clear_cnt <= clear_cnt + PAL_AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clear_last)
      state_d = ST_RUN;
  end

  // CPU port: component 3 aliases blue; the sequencer owns the write port while clearing
  assign cpu_comp = A[11:10];
  assign cpu_addr = A[PAL_AW:1];
  assign cpu_we   = MWR & PAL_CS & BYTE_SEL[0] & ~busy;

  assign wr_addr = busy ? clear_cnt : cpu_addr;
  assign wr_data = busy ? 5'd0 : DIN[4:0];
  assign wr_r    = ~reset & (busy | (cpu_we & (cpu_comp == 2'd0)));
  assign wr_g    = ~reset & (busy | (cpu_we & (cpu_comp == 2'd1)));
  assign wr_b    = ~reset & (busy | (cpu_we & cpu_comp[1]));

  always_ff @(posedge CLK_32M) begin
    if (wr_r) pal_r[wr_addr] <= wr_data;
    if (wr_g) pal_g[wr_addr] <= wr_data;
    if (wr_b) pal_b[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK_32M) begin
    if (reset)
      cpu_rd <= 5'd0;
    else if (cpu_comp == 2'd0)
      cpu_rd <= pal_r[cpu_addr];
    else if (cpu_comp == 2'd1)
      cpu_rd <= pal_g[cpu_addr];
    else
      cpu_rd <= pal_b[cpu_addr];
  end

  assign DOUT       = {11'h7FF, cpu_rd};
  assign DOUT_VALID = MRD & PAL_CS;

  // Layer priority, first opaque layer wins
  assign spr_op = layer_en[0] & (spr_pix[3:0] != 4'd0);
  assign bga_op = layer_en[1] & (bga_pix[3:0] != 4'd0);
  assign bgb_op = layer_en[2] & (bgb_pix[3:0] != 4'd0);

  always_comb begin
    pix_idx = 9'h000;
    if (bga_op && bga_prio)
      pix_idx = {1'b0, bga_pix};
    else if (bgb_op && bgb_prio)
      pix_idx = {1'b0, bgb_pix};
    else if (spr_op)
      pix_idx = {1'b1, spr_pix};
    else if (bga_op)
      pix_idx = {1'b0, bga_pix};
    else if (bgb_op)
      pix_idx = {1'b0, bgb_pix};
  end

  // Video pipeline: index -> RAM read -> blanked RGB
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      s1_idx   <= '0;
      s1_blank <= 1'b0;
      s2_blank <= 1'b0;
    end else if (CE_PIX) begin
      s1_idx   <= PAL_AW'(pix_idx);
      s1_blank <= HBLK | VBLK;
      s2_blank <= s1_blank;
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      s2_r <= 5'd0;
      s2_g <= 5'd0;
      s2_b <= 5'd0;
    end else if (CE_PIX) begin
      s2_r <= pal_r[s1_idx];
      s2_g <= pal_g[s1_idx];
      s2_b <= pal_b[s1_idx];
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (reset || busy) begin
      red   <= 5'd0;
      green <= 5'd0;
      blue  <= 5'd0;
    end else if (CE_PIX) begin
      red   <= s2_blank ? 5'd0 : s2_r;
      green <= s2_blank ? 5'd0 : s2_g;
      blue  <= s2_blank ? 5'd0 : s2_b;
    end
  end

endmodule

// File: tb/tb_obj_bg_palette_mixer.sv
// tb/tb_obj_bg_palette_mixer.sv - scoreboard bench for obj_bg_palette_mixer
module tb_obj_bg_palette_mixer;

  logic        CLK_32M = 1'b0;
  logic        reset, CE_PIX;
  logic [15:0] DIN, DOUT;
  logic        DOUT_VALID;
  logic [19:0] A;
  logic [1:0]  BYTE_SEL;
  logic        PAL_CS, MRD, MWR, HBLK, VBLK;
  logic [7:0]  spr_pix, bga_pix, bgb_pix;
  logic        bga_prio, bgb_prio;
  logic [2:0]  layer_en;
  logic        busy;
  logic [4:0]  red, green, blue;

  obj_bg_palette_mixer dut (
    .CLK_32M(CLK_32M), .reset(reset), .CE_PIX(CE_PIX), .DIN(DIN), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .A(A), .BYTE_SEL(BYTE_SEL), .PAL_CS(PAL_CS),
    .MRD(MRD), .MWR(MWR), .HBLK(HBLK), .VBLK(VBLK), .spr_pix(spr_pix),
    .bga_pix(bga_pix), .bga_prio(bga_prio), .bgb_pix(bgb_pix), .bgb_prio(bgb_prio),
    .layer_en(layer_en), .busy(busy), .red(red), .green(green), .blue(blue)
  );

  always #5 CLK_32M = ~CLK_32M;

  int checks = 0;
  int errors = 0;

  logic [14:0] model [0:511];
  int          tick_cnt = 0;
  int          q_tick[$];
  logic [14:0] q_rgb[$];
  logic [14:0] last_exp;
  bit          last_valid = 0;

  function automatic logic [8:0] ref_idx(input logic [7:0] spr, input logic [7:0] bga,
                                         input logic bgap, input logic [7:0] bgb,
                                         input logic bgbp, input logic [2:0] en);
    bit s, a, b;
    s = en[0] && (spr[3:0] != 0);
    a = en[1] && (bga[3:0] != 0);
    b = en[2] && (bgb[3:0] != 0);
    if (a && bgap) return {1'b0, bga};
    if (b && bgbp) return {1'b0, bgb};
    if (s)         return {1'b1, spr};
    if (a)         return {1'b0, bga};
    if (b)         return {1'b0, bgb};
    return 9'h000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) model[i] = 15'h0;
    q_tick.delete();
    q_rgb.delete();
    last_valid = 0;
  endtask

  task automatic pixel(input logic [7:0] spr, input logic [7:0] bga, input logic bgap,
                       input logic [7:0] bgb, input logic bgbp, input logic [2:0] en,
                       input logic hb, input logic vb, input bit track, input int gap);
    logic [14:0] exp;
    spr_pix = spr; bga_pix = bga; bga_prio = bgap; bgb_pix = bgb; bgb_prio = bgbp;
    layer_en = en; HBLK = hb; VBLK = vb; CE_PIX = 1'b1;
    @(posedge CLK_32M);
    tick_cnt++;
    if (track) begin
      q_tick.push_back(tick_cnt);
      q_rgb.push_back((hb | vb) ? 15'h0 : model[ref_idx(spr, bga, bgap, bgb, bgbp, en)]);
    end
    @(negedge CLK_32M);
    CE_PIX = 1'b0;
    last_valid = 0;
    if (q_tick.size() > 0 && q_tick[0] + 2 == tick_cnt) begin
      void'(q_tick.pop_front());
      exp = q_rgb.pop_front();
      checks++;
      if ({red, green, blue} !== exp) begin
        errors++;
        $display("FAIL pixel_rgb tick %0d: got %h expected %h", tick_cnt, {red, green, blue}, exp);
      end
      last_exp = exp;
      last_valid = 1;
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge CLK_32M);
      @(negedge CLK_32M);
      if (last_valid) begin
        checks++;
        if ({red, green, blue} !== last_exp) begin
          errors++;
          $display("FAIL ce_hold: got %h expected %h", {red, green, blue}, last_exp);
        end
      end
    end
  endtask

  task automatic flush();
    pixel(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 0, 0);
    pixel(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic cpu_write(input logic [1:0] comp, input logic [8:0] entry,
                           input logic [4:0] data, input logic [1:0] bsel);
    A = {8'h00, comp, entry, 1'b0};
    DIN = {11'h5AA, data};
    BYTE_SEL = bsel; PAL_CS = 1'b1; MWR = 1'b1;
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    MWR = 1'b0; PAL_CS = 1'b0;
    if (bsel[0]) begin
      case (comp)
        2'd0:    model[entry][14:10] = data;
        2'd1:    model[entry][9:5]   = data;
        default: model[entry][4:0]   = data;
      endcase
    end
  endtask

  task automatic set_entry(input logic [8:0] entry, input logic [4:0] r,
                           input logic [4:0] g, input logic [4:0] b);
    cpu_write(2'd0, entry, r, 2'b01);
    cpu_write(2'd1, entry, g, 2'b01);
    cpu_write(2'd2, entry, b, 2'b01);
  endtask

  task automatic cpu_read_check(input logic [1:0] comp, input logic [8:0] entry,
                                input logic [15:0] exp);
    A = {8'h00, comp, entry, 1'b0};
    PAL_CS = 1'b1; MRD = 1'b1;
    #1;
    checks++;
    if (DOUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL dout_valid_on: got %b expected 1", DOUT_VALID);
    end
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    checks++;
    if (DOUT !== exp) begin
      errors++;
      $display("FAIL cpu_read comp %0d entry %h: got %h expected %h", comp, entry, DOUT, exp);
    end
    MRD = 1'b0;
    #1;
    checks++;
    if (DOUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL dout_valid_off: got %b expected 0", DOUT_VALID);
    end
    PAL_CS = 1'b0;
  endtask

  task automatic count_clear(input string name, input int write_at);
    int cnt;
    bit rgb_bad;
    cnt = 0;
    rgb_bad = 0;
    while (busy === 1'b1 && cnt < 600) begin
      if (cnt == write_at) begin
        A = {8'h00, 2'd0, 9'h005, 1'b0};
        DIN = 16'h001F; BYTE_SEL = 2'b01; PAL_CS = 1'b1; MWR = 1'b1;
      end
      @(posedge CLK_32M);
      @(negedge CLK_32M);
      MWR = 1'b0; PAL_CS = 1'b0;
      if ({red, green, blue} !== 15'h0) rgb_bad = 1;
      cnt++;
    end
    checks++;
    if (cnt != 512) begin
      errors++;
      $display("FAIL %s busy_clocks: got %0d expected 512", name, cnt);
    end
    checks++;
    if (rgb_bad) begin
      errors++;
      $display("FAIL %s rgb_during_clear: got nonzero expected 0", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    reset = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b1 || {red, green, blue} !== 15'h0 || DOUT !== 16'hFFE0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b rgb=%h dout=%h expected busy=1 rgb=0 dout=ffe0",
               busy, {red, green, blue}, DOUT);
    end
    count_clear("first_clear", -1);
    cpu_read_check(2'd0, 9'h000, 16'hFFE0);
    cpu_read_check(2'd1, 9'h123, 16'hFFE0);
    cpu_read_check(2'd2, 9'h1FF, 16'hFFE0);
  endtask

  task automatic test_cpu_access();
    cpu_write(2'd0, 9'h123, 5'h1F, 2'b01);
    cpu_write(2'd1, 9'h123, 5'h10, 2'b01);
    cpu_write(2'd2, 9'h123, 5'h03, 2'b01);
    cpu_read_check(2'd0, 9'h123, 16'hFFFF);
    cpu_read_check(2'd1, 9'h123, 16'hFFF0);
    cpu_read_check(2'd2, 9'h123, 16'hFFE3);
    cpu_read_check(2'd3, 9'h123, 16'hFFE3);
    cpu_write(2'd0, 9'h123, 5'h00, 2'b10);
    cpu_read_check(2'd0, 9'h123, 16'hFFFF);
    cpu_write(2'd3, 9'h124, 5'h0E, 2'b01);
    cpu_read_check(2'd2, 9'h124, 16'hFFEE);
    pixel(8'h23, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    flush();
  endtask

  task automatic test_priority();
    set_entry(9'h121, 5'h01, 5'h02, 5'h03);
    set_entry(9'h045, 5'h04, 5'h05, 5'h06);
    set_entry(9'h017, 5'h07, 5'h08, 5'h09);
    set_entry(9'h000, 5'h0A, 5'h0B, 5'h0C);
    set_entry(9'h040, 5'h11, 5'h12, 5'h13);
    pixel(8'h21, 8'h45, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b1, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h40, 1'b1, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b0, 8'h17, 1'b1, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b1, 8'h17, 1'b1, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h00, 8'h45, 1'b0, 8'h17, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h00, 8'h40, 1'b0, 8'h17, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h20, 8'h40, 1'b1, 8'h10, 1'b1, 3'b111, 1'b0, 1'b0, 1, 0);
    flush();
  endtask

  task automatic test_layer_enable();
    pixel(8'h21, 8'h00, 1'b0, 8'h17, 1'b0, 3'b110, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b1, 8'h17, 1'b0, 3'b101, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b0, 8'h17, 1'b1, 3'b000, 1'b0, 1'b0, 1, 0);
    pixel(8'h21, 8'h45, 1'b0, 8'h17, 1'b1, 3'b011, 1'b0, 1'b0, 1, 0);
    flush();
  endtask

  task automatic test_blanking();
    pixel(8'h23, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h23, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1, 1'b0, 1, 0);
    pixel(8'h21, 8'h00, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    pixel(8'h00, 8'h45, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b1, 1, 0);
    pixel(8'h00, 8'h45, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 1, 0);
    flush();
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    for (int i = 0; i < 8; i++) begin
      e = 9'($urandom_range(0, 511));
      set_entry(e, 5'($urandom), 5'($urandom), 5'($urandom));
    end
    for (int i = 0; i < 24; i++)
      pixel(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0, 1, $urandom_range(0, 2));
    flush();
    checks++;
    if (q_tick.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_tick.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    reset = 1'b1;
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK_32M);
      @(negedge CLK_32M);
    end
    reset = 1'b1;
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    reset = 1'b0;
    count_clear("restart_clear", 100);
    cpu_read_check(2'd0, 9'h005, 16'hFFE0);
    cpu_read_check(2'd2, 9'h123, 16'hFFE0);
  endtask

  initial begin
    reset = 1'b1; CE_PIX = 1'b0; DIN = '0; A = '0; BYTE_SEL = '0; PAL_CS = 1'b0;
    MRD = 1'b0; MWR = 1'b0; HBLK = 1'b0; VBLK = 1'b0; spr_pix = '0; bga_pix = '0;
    bgb_pix = '0; bga_prio = 1'b0; bgb_prio = 1'b0; layer_en = 3'b111;
    @(negedge CLK_32M);
    test_reset();
    test_cpu_access();
    test_priority();
    test_layer_enable();
    test_blanking();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
